// File: rtl/regfile_sb.sv
// regfile_sb: parametrised 2-read/1-write integer register file with a
// per-register busy scoreboard for pending long-latency writes.
//
// Parameters:
//   XLEN     data width of each register
//   NREGS    number of architectural registers (2..64)
//   ZERO_REG 1 = register 0 reads zero, ignores writes, never goes busy
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   A1, A2            read addresses      -> RD1, RD2   (combinational)
//                                         -> BUSY1, BUSY2 (combinational)
//   A3, WD3, WE3      write port; a write also clears the busy bit of A3
//   SA, SE            scoreboard set: marks SA as having a pending write
//   FLUSH             clears every busy bit, highest priority
//   NBUSY             registered count of busy registers
//
// Build option:
//   REGFILE_BYPASS_EN  when defined, a same-cycle write is forwarded to the
//                      read ports and clears their busy indication, unless
//                      the same register is re-marked busy in that cycle.

module regfile_sb #(
    parameter  int XLEN     = 32,
    parameter  int NREGS    = 32,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    input  logic [AW-1:0]   A3,
    input  logic [XLEN-1:0] WD3,
    input  logic            WE3,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    input  logic [AW-1:0]   SA,
    input  logic            SE,
    input  logic            FLUSH,
    output logic            BUSY1,
    output logic            BUSY2,
    output logic [AW:0]     NBUSY
);

    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic [NREGS-1:0] wr_hit;
    logic [NREGS-1:0] set_hit;
    logic [AW:0]      nbusy_q;
    logic [AW:0]      nbusy_nxt;

    logic [XLEN-1:0] rd1_st;
    logic [XLEN-1:0] rd2_st;
    logic            bs1_st;
    logic            bs2_st;

    // Register 0 is read-only zero when ZERO_REG is set.
    function automatic logic writable(input int i);
        return !(ZERO_REG != 0 && i == 0);
    endfunction

    // One-hot decode of write and set.  Addresses at or above NREGS match
    // no entry, so they leave all state untouched.
    always_comb begin
        wr_hit  = '0;
        set_hit = '0;
        for (int i = 0; i < NREGS; i++) begin
            wr_hit[i]  = WE3 && (A3 == AW'(i)) && writable(i);
            set_hit[i] = SE && (SA == AW'(i)) && writable(i);
        end
    end

    // Flush beats everything; a set is applied after the write-clear so a
    // new producer issued in the same cycle keeps the register busy.
    always_comb begin
        if (FLUSH) begin
            busy_nxt = '0;
        end else begin
            busy_nxt = (busy & ~wr_hit) | set_hit;
        end
    end

    always_comb begin
        nbusy_nxt = '0;
        for (int i = 0; i < NREGS; i++) begin
            nbusy_nxt = nbusy_nxt + (AW+1)'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_hit[i]) begin
                    regs[i] <= WD3;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= '0;
            nbusy_q <= '0;
        end else begin
            busy    <= busy_nxt;
            nbusy_q <= nbusy_nxt;
        end
    end

    // Stored-state read muxes; out-of-range addresses and the zero
    // register fall through to the zero default.
    always_comb begin
        rd1_st = '0;
        rd2_st = '0;
        bs1_st = 1'b0;
        bs2_st = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (writable(i) && A1 == AW'(i)) begin
                rd1_st = regs[i];
                bs1_st = busy[i];
            end
            if (writable(i) && A2 == AW'(i)) begin
                rd2_st = regs[i];
                bs2_st = busy[i];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic wr_ok;
    logic set_ok;
    logic fwd1;
    logic fwd2;

    assign wr_ok  = |wr_hit;
    assign set_ok = |set_hit;
    assign fwd1   = wr_ok && (A3 == A1);
    assign fwd2   = wr_ok && (A3 == A2);

    assign RD1   = fwd1 ? WD3 : rd1_st;
    assign RD2   = fwd2 ? WD3 : rd2_st;
    assign BUSY1 = fwd1 ? (set_ok && SA == A1) : bs1_st;
    assign BUSY2 = fwd2 ? (set_ok && SA == A2) : bs2_st;
`else
    assign RD1   = rd1_st;
    assign RD2   = rd2_st;
    assign BUSY1 = bs1_st;
    assign BUSY2 = bs2_st;
`endif

    assign NBUSY = nbusy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scenarios plus randomized checking of regfile_sb
// against a behavioural model, on a full and a non-power-of-two instance.

module tb_regfile_sb;

    logic        clk;
    logic        rst_n;
    logic [4:0]  A1, A2, A3, SA;
    logic [31:0] WD3;
    logic        WE3, SE, FLUSH;

    logic [31:0] RD1, RD2, RD1b, RD2b;
    logic        BUSY1, BUSY2, BUSY1b, BUSY2b;
    logic [5:0]  NBUSY, NBUSYb;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_reg  [2][32];
    bit          m_busy [2][32];
    int          nr [2] = '{32, 20};

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regfile_sb dut (
        .clk(clk), .rst_n(rst_n),
        .A1(A1), .A2(A2), .A3(A3), .WD3(WD3), .WE3(WE3),
        .RD1(RD1), .RD2(RD2),
        .SA(SA), .SE(SE), .FLUSH(FLUSH),
        .BUSY1(BUSY1), .BUSY2(BUSY2), .NBUSY(NBUSY)
    );

    regfile_sb #(.XLEN(32), .NREGS(20), .ZERO_REG(1)) dut20 (
        .clk(clk), .rst_n(rst_n),
        .A1(A1), .A2(A2), .A3(A3), .WD3(WD3), .WE3(WE3),
        .RD1(RD1b), .RD2(RD2b),
        .SA(SA), .SE(SE), .FLUSH(FLUSH),
        .BUSY1(BUSY1b), .BUSY2(BUSY2b), .NBUSY(NBUSYb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        WE3 = 0; SE = 0; FLUSH = 0;
    endtask

    task automatic test_reset;
        idle();
        A1 = 0; A2 = 0; A3 = 0; SA = 0; WD3 = 0;
        rst_n = 0;
        tick();
        for (int a = 0; a < 32; a++) begin
            A1 = 5'(a);
            A2 = 5'(31 - a);
            #1;
            total++;
            if (RD1 !== 32'd0 || RD2 !== 32'd0) begin
                bad++;
                $display("FAIL reset_rd a=%0d got %h/%h want 0", a, RD1, RD2);
            end
            total++;
            if (BUSY1 !== 1'b0 || BUSY2 !== 1'b0) begin
                bad++;
                $display("FAIL reset_busy a=%0d got %b/%b want 0", a, BUSY1, BUSY2);
            end
        end
        total++;
        if (NBUSY !== 6'd0 || NBUSYb !== 6'd0) begin
            bad++;
            $display("FAIL reset_nbusy got %0d/%0d want 0", NBUSY, NBUSYb);
        end
        rst_n = 1;
        tick();
    endtask

    task automatic test_write_read;
        WE3 = 1; A3 = 5; WD3 = 32'hDEADBEEF;
        tick();
        idle();
        A1 = 5; A2 = 0;
        #1;
        total++;
        if (RD1 !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL wr_rd1 got %h want deadbeef", RD1);
        end
        total++;
        if (RD2 !== 32'd0) begin
            bad++;
            $display("FAIL wr_rd2 got %h want 0", RD2);
        end
    endtask

    task automatic test_zero_reg;
        WE3 = 1; A3 = 0; WD3 = 32'h1234;
        tick();
        idle();
        A1 = 0;
        #1;
        total++;
        if (RD1 !== 32'd0) begin
            bad++;
            $display("FAIL zero_rd got %h want 0", RD1);
        end
        SE = 1; SA = 0;
        tick();
        idle();
        total++;
        if (NBUSY !== 6'd0 || BUSY1 !== 1'b0) begin
            bad++;
            $display("FAIL zero_busy got n=%0d b=%b want 0", NBUSY, BUSY1);
        end
    endtask

    task automatic test_busy;
        SE = 1; SA = 7;
        tick();
        idle();
        A1 = 7;
        #1;
        total++;
        if (BUSY1 !== 1'b1 || NBUSY !== 6'd1) begin
            bad++;
            $display("FAIL busy_set got b=%b n=%0d want 1/1", BUSY1, NBUSY);
        end
        WE3 = 1; A3 = 7; WD3 = 32'h55;
        tick();
        idle();
        #1;
        total++;
        if (BUSY1 !== 1'b0 || NBUSY !== 6'd0 || RD1 !== 32'h55) begin
            bad++;
            $display("FAIL busy_clr got b=%b n=%0d rd=%h want 0/0/55",
                     BUSY1, NBUSY, RD1);
        end
    endtask

    task automatic test_set_write_flush;
        SE = 1; SA = 9; WE3 = 1; A3 = 9; WD3 = 32'h99;
        tick();
        idle();
        A1 = 9;
        #1;
        total++;
        if (BUSY1 !== 1'b1 || NBUSY !== 6'd1 || RD1 !== 32'h99) begin
            bad++;
            $display("FAIL set_wins got b=%b n=%0d rd=%h want 1/1/99",
                     BUSY1, NBUSY, RD1);
        end
        SE = 1; SA = 3;
        tick();
        SA = 4;
        tick();
        idle();
        total++;
        if (NBUSY !== 6'd3) begin
            bad++;
            $display("FAIL three_busy got %0d want 3", NBUSY);
        end
        FLUSH = 1; SE = 1; SA = 10;
        tick();
        idle();
        total++;
        if (NBUSY !== 6'd0) begin
            bad++;
            $display("FAIL flush_n got %0d want 0", NBUSY);
        end
        for (int a = 0; a < 32; a++) begin
            A1 = 5'(a);
            A2 = 5'(a);
            #1;
            total++;
            if (BUSY1 !== 1'b0 || BUSY2 !== 1'b0) begin
                bad++;
                $display("FAIL flush_b a=%0d got %b/%b want 0", a, BUSY1, BUSY2);
            end
        end
    endtask

    task automatic test_bypass_async_reset;
        logic [31:0] want;
        logic        wantb;
        WE3 = 1; A3 = 12; WD3 = 32'h1111; SE = 0;
        tick();
        idle();
        SE = 1; SA = 12;
        tick();
        idle();
        WE3 = 1; A3 = 12; WD3 = 32'hA5A5; A2 = 12;
        #1;
        want  = BYP ? 32'hA5A5 : 32'h1111;
        wantb = BYP ? 1'b0 : 1'b1;
        total++;
        if (RD2 !== want || BUSY2 !== wantb) begin
            bad++;
            $display("FAIL bypass_same got %h/%b want %h/%b",
                     RD2, BUSY2, want, wantb);
        end
        tick();
        idle();
        #1;
        total++;
        if (RD2 !== 32'hA5A5 || BUSY2 !== 1'b0) begin
            bad++;
            $display("FAIL bypass_next got %h/%b want a5a5/0", RD2, BUSY2);
        end
        SE = 1; SA = 12;
        tick();
        idle();
        #2;
        rst_n = 0;
        #1;
        total++;
        if (RD2 !== 32'd0 || NBUSY !== 6'd0 || BUSY2 !== 1'b0) begin
            bad++;
            $display("FAIL async_rst got rd=%h n=%0d b=%b want 0",
                     RD2, NBUSY, BUSY2);
        end
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_out_of_range;
        WE3 = 1; A3 = 25; WD3 = 32'hBAD0; SE = 1; SA = 22;
        tick();
        idle();
        A1 = 25; A2 = 22;
        #1;
        total++;
        if (NBUSYb !== 6'd0) begin
            bad++;
            $display("FAIL oor_nbusy got %0d want 0", NBUSYb);
        end
        total++;
        if (RD1b !== 32'd0 || BUSY1b !== 1'b0 || BUSY2b !== 1'b0) begin
            bad++;
            $display("FAIL oor_rd got %h/%b/%b want 0", RD1b, BUSY1b, BUSY2b);
        end
        WE3 = 1; A3 = 19; WD3 = 32'h1919; SE = 1; SA = 19;
        tick();
        idle();
        A1 = 19;
        #1;
        total++;
        if (RD1b !== 32'h1919 || BUSY1b !== 1'b1 || NBUSYb !== 6'd1) begin
            bad++;
            $display("FAIL top_reg got %h/%b/%0d want 1919/1/1",
                     RD1b, BUSY1b, NBUSYb);
        end
    endtask

    function automatic void exp_port(input int k, input logic [4:0] a,
                                     output logic [31:0] rd,
                                     output logic bz);
        bit wr;
        bit st;
        wr = WE3 && int'(A3) < nr[k] && A3 != 0;
        st = SE && int'(SA) < nr[k] && SA != 0;
        rd = (int'(a) < nr[k] && a != 0) ? m_reg[k][a] : 32'd0;
        bz = (int'(a) < nr[k]) ? m_busy[k][a] : 1'b0;
        if (BYP && wr && A3 == a) begin
            rd = WD3;
            bz = st && SA == a;
        end
    endfunction

    task automatic test_random;
        logic [31:0] e1, e2;
        logic        eb1, eb2;
        int          cnt;
        idle();
        rst_n = 0;
        tick();
        rst_n = 1;
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 32; r++) begin
                m_reg[k][r]  = '0;
                m_busy[k][r] = 0;
            end
        repeat (3000) begin
            WE3   = ($urandom_range(0, 2) != 0);
            A3    = 5'($urandom);
            WD3   = $urandom;
            SE    = ($urandom_range(0, 1) != 0);
            SA    = ($urandom_range(0, 3) == 0) ? A3 : 5'($urandom);
            FLUSH = ($urandom_range(0, 40) == 0);
            A1    = ($urandom_range(0, 3) == 0) ? A3 : 5'($urandom);
            A2    = ($urandom_range(0, 3) == 0) ? SA : 5'($urandom);
            #2;
            for (int k = 0; k < 2; k++) begin
                exp_port(k, A1, e1, eb1);
                exp_port(k, A2, e2, eb2);
                cnt = 0;
                for (int r = 0; r < 32; r++) cnt += int'(m_busy[k][r]);
                total++;
                if ((k == 0 ? RD1 : RD1b) !== e1 ||
                    (k == 0 ? RD2 : RD2b) !== e2) begin
                    bad++;
                    $display("FAIL rnd_rd k=%0d got %h/%h want %h/%h", k,
                             k == 0 ? RD1 : RD1b, k == 0 ? RD2 : RD2b, e1, e2);
                end
                total++;
                if ((k == 0 ? BUSY1 : BUSY1b) !== eb1 ||
                    (k == 0 ? BUSY2 : BUSY2b) !== eb2) begin
                    bad++;
                    $display("FAIL rnd_busy k=%0d got %b/%b want %b/%b", k,
                             k == 0 ? BUSY1 : BUSY1b,
                             k == 0 ? BUSY2 : BUSY2b, eb1, eb2);
                end
                total++;
                if ((k == 0 ? NBUSY : NBUSYb) !== 6'(cnt)) begin
                    bad++;
                    $display("FAIL rnd_nbusy k=%0d got %0d want %0d", k,
                             k == 0 ? NBUSY : NBUSYb, cnt);
                end
            end
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                bit wr;
                bit st;
                wr = WE3 && int'(A3) < nr[k] && A3 != 0;
                st = SE && int'(SA) < nr[k] && SA != 0;
                if (wr) m_reg[k][A3] = WD3;
                if (FLUSH) begin
                    for (int r = 0; r < 32; r++) m_busy[k][r] = 0;
                end else begin
                    if (wr) m_busy[k][A3] = 0;
                    if (st) m_busy[k][SA] = 1;
                end
            end
            #1;
        end
        idle();
    endtask

    initial begin
        rst_n = 1;
        idle();
        A1 = 0; A2 = 0; A3 = 0; SA = 0; WD3 = 0;
        #2;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_busy();
        test_set_write_flush();
        test_bypass_async_reset();
        test_out_of_range();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the core's 2-read/1-write integer register file.
- Generalised in data width and register count.
- Adds a per-register busy scoreboard so the pipeline can detect pending writes from long-latency producers (loads, multi-cycle ALU ops).
- Sits in the decode stage between the instruction decoder and the ALU operand muxes.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (2..64, need not be a power of two).
- ZERO_REG, 1, when 1 register 0 is hardwired to zero and can never be marked busy.
- AW (localparam), $clog2(NREGS), address width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- A1  in  AW  read address, port 1
- A2  in  AW  read address, port 2
- A3  in  AW  write address
- WD3  in  XLEN  write data
- WE3  in  1  write enable
- RD1  out  XLEN  read data, port 1
- RD2  out  XLEN  read data, port 2
- SA  in  AW  scoreboard set address
- SE  in  1  scoreboard set enable: marks SA as having a pending write
- FLUSH  in  1  clears every busy bit (pipeline flush)
- BUSY1  out  1  register at A1 has a pending write
- BUSY2  out  1  register at A2 has a pending write
- NBUSY  out  AW+1  count of registers currently busy

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers are cleared to 0.
  - All busy bits are cleared; NBUSY = 0.
  - RD1 and RD2 read 0.
  - Reset applies immediately and overrides any in-flight write or set.
- Reads:
  - Combinational, zero latency: RDn = reg[An].
  - If An >= NREGS, RDn = 0 and BUSYn = 0.
  - If ZERO_REG = 1 and An == 0, RDn = 0.
- Write:
  - On the rising edge when WE3 = 1 and A3 < NREGS, reg[A3] <= WD3.
  - Ignored when ZERO_REG = 1 and A3 == 0.
  - Without bypass, the written value is visible on RDn from the cycle after the edge.
- Busy scoreboard, updated on the rising edge:
  - FLUSH = 1: all busy bits <= 0. FLUSH has priority over SE and over write-clear.
  - Otherwise, a write as defined above clears busy[A3].
  - Otherwise, SE = 1 with SA < NREGS (and not register 0 when ZERO_REG = 1) sets busy[SA].
  - SE and a write to the same address in the same cycle: set wins, and the register remains busy (a new producer has been issued).
  - SE on an already-busy register: no change. A write to a non-busy register: busy unaffected.
- BUSYn = busy[An], combinational from state.
- NBUSY is a registered population count, updated in the same edge as the busy bits. It always equals the number of set busy bits; maximum value is NREGS (or NREGS-1 with ZERO_REG = 1).
- Out-of-range A3 or SA: no state change at all.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-first forwarding. When WE3 = 1 and A3 == An (valid, writable), RDn = WD3 in the same cycle.
  - BUSYn is forced to 0 for that port unless SE = 1 with SA == An in the same cycle.
- Not defined:
  - Reads return stored state only.
  - BUSYn reflects stored busy bits only; a same-cycle write shows on the next cycle.

Test Plan:
- Reset, then read all addresses on both ports -> RD1 = RD2 = 0 for every address; BUSY1 = BUSY2 = 0; NBUSY = 0.
- Write 32'hDEADBEEF to reg 5, then A1 = 5, A2 = 0 next cycle -> RD1 = 32'hDEADBEEF, RD2 = 0.
- Write 32'h1234 to reg 0 with ZERO_REG = 1 -> RD1 at A1 = 0 reads 0. SE with SA = 0 -> NBUSY stays 0.
- SE with SA = 7, then next cycle A1 = 7 -> BUSY1 = 1, NBUSY = 1.
  - Then WE3 = 1, A3 = 7, WD3 = 32'h55 -> next cycle BUSY1 = 0, NBUSY = 0, RD1 = 32'h55.
- Same cycle: SE with SA = 9, WE3 = 1, A3 = 9 -> busy[9] = 1, reg[9] updated, NBUSY = 1.
  - Then set regs 3 and 4 busy and assert FLUSH together with SE at SA = 10 -> NBUSY = 0 and all busy bits clear.
- Bypass and reset:
  - With REGFILE_BYPASS_EN: WE3 = 1, A3 = 12, WD3 = 32'hA5A5, A2 = 12 -> RD2 = 32'hA5A5 in the same cycle.
  - Without REGFILE_BYPASS_EN: the same stimulus gives the old value in that cycle and 32'hA5A5 the cycle after.
  - Asserting rst_n low mid-cycle zeroes RD2 immediately, without waiting for a clock edge.
